sequence_display_ctrl: RTL and testbench

//  Plays the stored colour sequence of the memory game on the LEDs before each player turn.
//  - Walks memory addresses 0..rodada and shows each stored value for T_ON cycles, followed by a dark gap of T_OFF cycles.
//  - Sits between the game control unit (start/done handshake) and the datapath (sync-read sequence memory, LED outputs).
//  - Owns the memory address and the LED bus only while busy=1.

---
 rtl/sequence_display_ctrl_pkg.sv | 30 +++
 rtl/sequence_display_ctrl_if.sv | 38 +++
 rtl/sequence_display_ctrl_timer.sv | 32 +++
 rtl/sequence_display_ctrl.sv | 100 ++++++++++
 tb/tb_sequence_display_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/sequence_display_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : game_pkg
// Brief    : Shared state codes, bus width defaults and LED constants for the
//            memory-game sequence display controller.
// Revision : 1.0 - initial release
// =============================================================================
package game_pkg;

  localparam int c_addr_w = 4;
  localparam int c_data_w = 4;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_SHOW = 4'd2;
  localparam logic [3:0] S_GAP  = 4'd3;
  localparam logic [3:0] S_DONE = 4'd4;

  typedef enum logic [3:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_SHOW = S_SHOW,
    ST_GAP  = S_GAP,
    ST_DONE = S_DONE
  } state_t;

  localparam logic [c_data_w-1:0] c_dark = '0;

endpackage
`default_nettype wire

// File: rtl/sequence_display_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : sequence_display_ctrl_if
// Brief    : Control-unit handshake plus sequence-memory/LED bus of the
//            display controller. Optional abort line under SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// =============================================================================
interface sequence_display_ctrl_if
  import game_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) ();

  logic              start;
  logic [ADDR_W-1:0] rodada;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] leds;
  logic              busy;
  logic              done;
  logic [3:0]        db_estado;
`ifdef SEQ_ABORT_EN
  logic              abort;

  modport master (output start, rodada, mem_data, abort,
                  input  mem_addr, leds, busy, done, db_estado);
  modport slave  (input  start, rodada, mem_data, abort,
                  output mem_addr, leds, busy, done, db_estado);
`else
  modport master (output start, rodada, mem_data,
                  input  mem_addr, leds, busy, done, db_estado);
  modport slave  (input  start, rodada, mem_data,
                  output mem_addr, leds, busy, done, db_estado);
`endif

endinterface
`default_nettype wire

// File: rtl/sequence_display_ctrl_timer.sv
`default_nettype none
// =============================================================================
// Module   : seq_timer
// Brief    : Loadable down-counter; expired is high at zero while not loading.
// Revision : 1.0 - initial release
// =============================================================================
module seq_timer #(
  parameter int WIDTH = 10
) (
  input  wire              clock,
  input  wire              reset,
  input  wire              load,
  input  wire [WIDTH-1:0]  load_val,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0) && !load;

endmodule
`default_nettype wire

// File: rtl/sequence_display_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : sequence_display_ctrl
// Brief    : Replays stored colour sequence 0..rodada on the LEDs (T_ON lit,
//            T_OFF dark per item). Optional abort input under SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module sequence_display_ctrl
  import game_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input wire                     clock,
  input wire                     reset,
  sequence_display_ctrl_if.slave bus
);

  localparam int c_tmr_w = $clog2(((T_ON > T_OFF) ? T_ON : T_OFF) + 1);
  // The load cycle itself counts as the first cycle of SHOW/GAP, hence T-2.
  localparam logic [c_tmr_w-1:0] c_on_load  = (T_ON  >= 2) ? c_tmr_w'(T_ON  - 2) : '0;
  localparam logic [c_tmr_w-1:0] c_off_load = (T_OFF >= 2) ? c_tmr_w'(T_OFF - 2) : '0;
  localparam logic c_on_single  = (T_ON  == 1);
  localparam logic c_off_single = (T_OFF == 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_rod;
  logic [DATA_W-1:0]   r_led;
  logic                r_entry;
  logic                w_tmr_load;
  logic [c_tmr_w-1:0]  w_tmr_val;
  logic                w_tmr_expired;
  logic                w_show_end;
  logic                w_gap_end;

  assign w_tmr_load = r_entry && ((r_state == ST_SHOW) || (r_state == ST_GAP));
  assign w_tmr_val  = (r_state == ST_SHOW) ? c_on_load : c_off_load;
  assign w_show_end = r_entry ? c_on_single  : w_tmr_expired;
  assign w_gap_end  = r_entry ? c_off_single : w_tmr_expired;

  seq_timer #(
    .WIDTH    (c_tmr_w)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_SHOW;
      ST_SHOW: if (w_show_end) w_state_next = ST_GAP;
      ST_GAP:  if (w_gap_end) w_state_next = (r_idx == r_rod) ? ST_DONE : ST_LOAD;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    if (bus.abort && ((r_state == ST_LOAD) || (r_state == ST_SHOW) || (r_state == ST_GAP)))
      w_state_next = ST_IDLE;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rod   <= '0;
      r_led   <= '0;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_entry <= (w_state_next != r_state);
      if ((r_state == ST_IDLE) && bus.start) begin
        r_rod <= bus.rodada;
        r_idx <= '0;
      end
      if (r_state == ST_LOAD)
        r_led <= bus.mem_data;
      // Compare-before-increment: the last item never advances idx, so no wrap.
      if ((r_state == ST_GAP) && (w_state_next == ST_LOAD))
        r_idx <= r_idx + 1'b1;
    end
  end

  assign bus.mem_addr  = r_idx;
  assign bus.leds      = (r_state == ST_SHOW) ? r_led : DATA_W'(c_dark);
  assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_SHOW) || (r_state == ST_GAP);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.db_estado = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sequence_display_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_sequence_display_ctrl
// Brief    : Directed self-checking bench for sequence_display_ctrl (T_ON=2,
//            T_OFF=1); abort scenario selected by SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sequence_display_ctrl;

  localparam int c_t_on  = 2;
  localparam int c_t_off = 1;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [3:0] mem [16];

  sequence_display_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  sequence_display_ctrl #(
    .ADDR_W (4),
    .DATA_W (4),
    .T_ON   (c_t_on),
    .T_OFF  (c_t_off)
  ) dut (
    .clock  (clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  // Memory read data follows the address within the LOAD cycle.
  assign bus.mem_data = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns in the LOAD cycle of item 0 (first cycle after the start edge).
  task automatic start_run(input logic [3:0] rod);
    bus.start  = 1'b1;
    bus.rodada = rod;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic play_check(input int rod, input bit poke);
    for (int i = 0; i <= rod; i++) begin
      check("load_state", 32'(bus.db_estado), 32'd1);
      check("load_addr",  32'(bus.mem_addr),  32'(i));
      check("load_leds",  32'(bus.leds),      32'd0);
      check("load_busy",  32'(bus.busy),      32'd1);
      check("load_done",  32'(bus.done),      32'd0);
      step();
      for (int t = 0; t < c_t_on; t++) begin
        check("show_state", 32'(bus.db_estado), 32'd2);
        check("show_leds",  32'(bus.leds),      32'(mem[i]));
        check("show_addr",  32'(bus.mem_addr),  32'(i));
        check("show_busy",  32'(bus.busy),      32'd1);
        if (poke && i == 1 && t == 0) begin
          bus.start  = 1'b1;
          bus.rodada = 4'd9;
        end
        step();
        bus.start = 1'b0;
      end
      for (int t = 0; t < c_t_off; t++) begin
        check("gap_state", 32'(bus.db_estado), 32'd3);
        check("gap_leds",  32'(bus.leds),      32'd0);
        check("gap_busy",  32'(bus.busy),      32'd1);
        step();
      end
    end
    check("done_pulse", 32'(bus.done),      32'd1);
    check("done_state", 32'(bus.db_estado), 32'd4);
    check("done_busy",  32'(bus.busy),      32'd0);
    check("done_addr",  32'(bus.mem_addr),  32'(rod));
    step();
    check("post_done",  32'(bus.done),      32'd0);
    check("post_state", 32'(bus.db_estado), 32'd0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.rodada = 4'd0;
`ifdef SEQ_ABORT_EN
    bus.abort  = 1'b0;
`endif
    for (int k = 0; k < 16; k++) mem[k] = 4'(k) ^ 4'h5;

    step();
    step();
    check("rst_state", 32'(bus.db_estado), 32'd0);
    check("rst_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_leds",  32'(bus.leds),      32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    rst_n = 1'b1;
    step();
    check("idle_hold", 32'(bus.db_estado), 32'd0);

    // Single item: leds lit two cycles, one dark, then done.
    mem[0] = 4'h1;
    start_run(4'd0);
    play_check(0, 1'b0);

    // Four items 8,4,2,1.
    mem[0] = 4'h8; mem[1] = 4'h4; mem[2] = 4'h2; mem[3] = 4'h1;
    start_run(4'd3);
    play_check(3, 1'b0);

    // Full sequence of 16 distinct words; done reports address 15.
    for (int k = 0; k < 16; k++) mem[k] = 4'(k) ^ 4'hA;
    start_run(4'd15);
    play_check(15, 1'b0);

    // Restart attempt and rodada change during item 1 are ignored.
    start_run(4'd2);
    play_check(2, 1'b1);
    bus.rodada = 4'd0;

    // Asynchronous reset during GAP of item 2.
    start_run(4'd3);
    for (int k = 0; k < 11; k++) step();
    check("pre_rst_gap", 32'(bus.db_estado), 32'd3);
    check("pre_rst_idx", 32'(bus.mem_addr),  32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_leds",  32'(bus.leds),      32'd0);
    check("arst_busy",  32'(bus.busy),      32'd0);
    check("arst_state", 32'(bus.db_estado), 32'd0);
    check("arst_addr",  32'(bus.mem_addr),  32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("arst_no_done", 32'(bus.done), 32'd0);
      step();
    end
    start_run(4'd1);
    play_check(1, 1'b0);

`ifdef SEQ_ABORT_EN
    start_run(4'd2);
    step();
    check("abort_in_show", 32'(bus.db_estado), 32'd2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_state", 32'(bus.db_estado), 32'd0);
    check("abort_leds",  32'(bus.leds),      32'd0);
    check("abort_busy",  32'(bus.busy),      32'd0);
    for (int k = 0; k < 14; k++) begin
      check("abort_no_done", 32'(bus.done), 32'd0);
      step();
    end
`else
    start_run(4'd2);
    play_check(2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
